// File: rtl/pwm_dac.sv
// pwm_dac: turns an unsigned wave sample into a single-bit PWM stream for an
// external RC low-pass DAC. A one-entry input buffer with a valid/ready
// handshake decouples the sample source from the PWM period. The duty value
// only changes at period boundaries (or on entry into RUN), so every pulse is
// glitch-free.
//
// Optional feature macro: UNDERRUN_CNT_EN
//   Defined   -> adds clr_underrun input and underrun_count[7:0] output, a
//                saturating count of boundaries that found the buffer empty.
//   Undefined -> neither port nor the counter exists.
module pwm_dac #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [PRE_W-1:0] prescale,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   output logic             sample_ready,
   output logic             pwm_out,
   output logic             period_start,
   output logic [WIDTH-1:0] duty
`ifdef UNDERRUN_CNT_EN
   ,
   input  logic             clr_underrun,
   output logic [7:0]       underrun_count
`endif
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [PRE_W-1:0] r_pre_cnt;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_duty;
   logic [WIDTH-1:0] r_buf;
   logic             r_buf_full;
   logic             r_pwm;
   logic             r_period_start;

   logic             w_start;     // IDLE -> RUN entry on this edge
   logic             w_tick;      // prescaled tick on this edge
   logic             w_boundary;  // last tick of a period on this edge
   logic             w_load;      // buffered sample becomes the new duty
   logic             w_accept;    // handshake completes on this edge

   // Next-state and per-edge event decode.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_tick      = 1'b0;
      w_boundary  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_state_nxt = ST_RUN;
               w_start     = 1'b1;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
            end else begin
               // >= lets a prescale decrease take effect on the very next clock
               w_tick     = (r_pre_cnt >= prescale);
               w_boundary = w_tick && (r_cnt == CNT_MAX);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Both decisions use the pre-edge buffer state, so an accept and a
   // consume can never happen on the same edge.
   assign w_load   = (w_start || w_boundary) && r_buf_full;
   assign w_accept = sample_valid && !r_buf_full;

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Prescaler, period counter, period_start pulse and registered PWM pin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pre_cnt      <= '0;
         r_cnt          <= '0;
         r_period_start <= 1'b0;
         r_pwm          <= 1'b0;
      end else begin
         if ((w_state_nxt == ST_IDLE) || w_start) begin
            r_pre_cnt <= '0;
            r_cnt     <= '0;
         end else if (w_tick) begin
            r_pre_cnt <= '0;
            r_cnt     <= r_cnt + CNT_ONE;  // natural wrap at the boundary
         end else begin
            r_pre_cnt <= r_pre_cnt + PRE_ONE;
         end
         r_period_start <= w_start || w_boundary;
         r_pwm          <= (r_state == ST_RUN) && (r_cnt < r_duty);
      end
   end

   // Buffer occupancy and the duty value in effect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf_full <= 1'b0;
         r_duty     <= '0;
      end else begin
         if (w_load) begin
            r_duty     <= r_buf;
            r_buf_full <= 1'b0;
         end else if (w_accept) begin
            r_buf_full <= 1'b1;
         end
      end
   end

   // Sample storage; only meaningful while r_buf_full is set.
   always_ff @(posedge clk) begin
      if (w_accept) r_buf <= sample_in;
   end

`ifdef UNDERRUN_CNT_EN
   logic [7:0] r_und_cnt;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Count boundaries that found no fresh sample; clear wins over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           r_und_cnt <= '0;
      else if (clr_underrun)              r_und_cnt <= '0;
      else if (w_boundary && !r_buf_full) r_und_cnt <= sat_inc8(r_und_cnt);
   end

   assign underrun_count = r_und_cnt;
`endif

   assign sample_ready = !r_buf_full;
   assign pwm_out      = r_pwm;
   assign period_start = r_period_start;
   assign duty         = r_duty;

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: randomized and directed stimulus for pwm_dac, checked every
// clock against a behavioural reference model through an expectation queue.
// Build with UNDERRUN_CNT_EN to also exercise the underrun counter.
module tb_pwm_dac;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] prescale = 4'd0;
   logic [7:0] sample_in = 8'd0;
   logic       sample_valid = 1'b0;
   logic       clr_drv = 1'b0;
   logic       sample_ready;
   logic       pwm_out;
   logic       period_start;
   logic [7:0] duty;
   logic [7:0] und_act;

   int n_tests = 0;
   int n_fail  = 0;
   bit rst_next = 1'b0;

   typedef struct packed {
      logic       pwm;
      logic       ps;
      logic       rdy;
      logic [7:0] duty;
      logic [7:0] und;
   } obs_t;

   obs_t exp_q[$];

   // Reference model state
   bit m_run = 1'b0;
   bit m_pwm = 1'b0;
   bit m_ps  = 1'b0;
   int m_pre = 0;
   int m_cnt = 0;
   int m_duty = 0;
   int m_und = 0;
   int buf_q[$];

   // Outputs sampled at the start of each cyc() call
   bit s_pwm;
   bit s_ps;

   pwm_dac #(.WIDTH(8), .PRE_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .prescale     (prescale),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .duty         (duty)
`ifdef UNDERRUN_CNT_EN
      ,
      .clr_underrun   (clr_drv),
      .underrun_count (und_act)
`endif
   );

`ifndef UNDERRUN_CNT_EN
   assign und_act = 8'd0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Advance the model by one clock edge using the inputs now applied.
   task automatic model_step();
      bit   take;
      bit   underrun;
      int   fill;
      obs_t e;
      take = 1'b0;
      underrun = 1'b0;
      if (!rst) begin
         m_run = 0; m_pre = 0; m_cnt = 0; m_duty = 0;
         m_pwm = 0; m_ps = 0; m_und = 0;
         buf_q.delete();
      end else begin
         fill  = buf_q.size();
         m_pwm = m_run && (m_cnt < m_duty);
         if (!enable) begin
            m_run = 0; m_pre = 0; m_cnt = 0; m_ps = 0;
         end else if (!m_run) begin
            m_run = 1; m_pre = 0; m_cnt = 0; m_ps = 1; take = 1;
         end else if (m_pre >= int'(prescale)) begin
            m_pre = 0;
            m_cnt = (m_cnt + 1) % 256;
            m_ps  = (m_cnt == 0);
            take  = m_ps;
            underrun = m_ps && (fill == 0);
         end else begin
            m_pre++;
            m_ps = 0;
         end
         if (fill > 0) begin
            if (take) m_duty = buf_q.pop_front();
         end else if (sample_valid) begin
            buf_q.push_back(int'(sample_in));
         end
         if (clr_drv) m_und = 0;
         else if (underrun && m_und < 255) m_und++;
      end
      e.pwm  = m_pwm;
      e.ps   = m_ps;
      e.rdy  = (buf_q.size() == 0);
      e.duty = 8'(m_duty);
`ifdef UNDERRUN_CNT_EN
      e.und  = 8'(m_und);
`else
      e.und  = 8'd0;
`endif
      exp_q.push_back(e);
   endtask

   // One clock of stimulus: sample outputs, apply inputs, predict next edge.
   task automatic cyc(input bit en, input int p, input bit v, input int d, input bit clr = 1'b0);
      @(negedge clk);
      #1;
      s_pwm = pwm_out;
      s_ps  = period_start;
      rst          = rst_next;
      enable       = en;
      prescale     = 4'(p);
      sample_valid = v;
      sample_in    = 8'(d);
      clr_drv      = clr;
      model_step();
   endtask

   // Monitor: compare DUT outputs with the oldest pending expectation.
   initial begin
      obs_t e;
      obs_t a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.pwm  = pwm_out;
            a.ps   = period_start;
            a.rdy  = sample_ready;
            a.duty = duty;
            a.und  = und_act;
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL cycle@%0t: got pwm=%b ps=%b rdy=%b duty=%0d und=%0d, expected pwm=%b ps=%b rdy=%b duty=%0d und=%0d",
                        $time, a.pwm, a.ps, a.rdy, a.duty, a.und, e.pwm, e.ps, e.rdy, e.duty, e.und);
            end
         end
      end
   end

   // Flush any buffered sample through an entry, then load s and start.
   task automatic load_and_start(input int p, input int s);
      cyc(0, p, 0, 0);
      cyc(1, p, 0, 0);
      cyc(0, p, 0, 0);
      cyc(0, p, 1, s);
      cyc(1, p, 0, 0);
   endtask

   // Measure period length and high time between the 2nd and 3rd period_start.
   task automatic measure(input int p, input int exp_len, input int exp_high, input string tag);
      int seen;
      int len;
      int hi;
      int limit;
      seen = 0; len = 0; hi = 0;
      limit = 3 * 256 * (p + 1) + 20;
      for (int i = 0; i < limit; i++) begin
         cyc(1, p, 0, 0);
         if (s_ps) begin
            seen++;
            if (seen == 3) break;
            len = 0;
            hi  = 0;
         end
         if (seen >= 1) begin
            len++;
            hi += int'(s_pwm);
         end
      end
      if (seen < 3) begin
         chk({tag, "_timeout"}, seen, 3);
      end else begin
         chk({tag, "_len"}, len, exp_len);
         chk({tag, "_high"}, hi, exp_high);
      end
   endtask

   task automatic async_reset_check();
      int guard;
      guard = 0;
      while (!m_pwm && guard < 2000) begin
         cyc(1, 0, 0, 0);
         guard++;
      end
      chk("rst_setup", m_pwm, 1);
      @(negedge clk);
      #1;
      chk("rst_pre_pwm", pwm_out, 1);
      rst = 1'b0;
      rst_next = 1'b0;
      #1;
      chk("rst_async_pwm", pwm_out, 0);
      chk("rst_async_ready", sample_ready, 1);
      chk("rst_async_duty", duty, 0);
      chk("rst_async_ps", period_start, 0);
      model_step();
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
      rst_next = 1'b1;
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("rst_resume_ps", s_ps, 1);
   endtask

   initial begin
      int count;
      int guard;
      int p;
      int off;
      int vprob;
      bit hold_valid;
      bit en;
      bit v;

      // Power-on reset
      #1 rst = 1'b0;
      #1;
      chk("por_pwm", pwm_out, 0);
      chk("por_ps", period_start, 0);
      chk("por_ready", sample_ready, 1);
      chk("por_duty", duty, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      rst_next = 1'b1;
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);

      // Basic duty and extremes
      load_and_start(0, 64);
      measure(0, 256, 64, "duty64");
      async_reset_check();
      load_and_start(0, 0);
      measure(0, 256, 0, "duty0");
      load_and_start(0, 255);
      measure(0, 256, 255, "duty255");

      // Prescale 3, then drop prescale to 0 mid-period
      load_and_start(3, 128);
      measure(3, 1024, 512, "pre3");
      guard = 0;
      while (!(m_cnt == 40 && m_pre == 2) && guard < 2000) begin
         cyc(1, 3, 0, 0);
         guard++;
      end
      for (int i = 0; i < 300; i++) cyc(1, 0, 0, 0);

      // Underrun: one sample then starve for three boundaries
      cyc(0, 0, 0, 0, 1'b1);
      load_and_start(0, 200);
      count = 0;
      for (int i = 0; i < 4 * 256 + 20 && count < 4; i++) begin
         cyc(1, 0, 0, 0);
         if (s_ps) count++;
      end
      chk("underrun_periods", count, 4);
      chk("underrun_duty", duty, 200);
`ifdef UNDERRUN_CNT_EN
      chk("underrun_count", und_act, 3);
`endif

      // Enable drop at cnt=100 with duty=150, then re-enable
      load_and_start(0, 150);
      guard = 0;
      while (m_cnt != 100 && guard < 600) begin
         cyc(1, 0, 0, 0);
         guard++;
      end
      chk("drop_reach", m_cnt, 100);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      chk("drop_pwm", s_pwm, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("reen_ps", s_ps, 1);
      chk("reen_duty", duty, 150);

      // Randomized segments
      for (int seg = 0; seg < 16 && n_fail < 40; seg++) begin
         p = $urandom_range(0, 2);
         off = 0;
         hold_valid = (seg % 3 == 0);
         vprob = (seg % 3 == 1) ? 1 : 0;
         for (int c = 0; c < 800; c++) begin
            en = 1'b1;
            if (off > 0) begin
               en = 1'b0;
               off--;
            end else if ($urandom_range(0, 299) == 0) begin
               off = $urandom_range(1, 20);
            end
            if ($urandom_range(0, 399) == 0) p = $urandom_range(0, 3);
            v = hold_valid ? 1'b1 : ($urandom_range(0, 199) < 2 + vprob * 8);
            cyc(en, p, v, $urandom_range(0, 255), $urandom_range(0, 499) == 0);
         end
      end

      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
